// File: rtl/os_array_pkg.sv
// Shared types and sizing helpers for the output-stationary array controller.
package os_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_READ,
        ST_DONE
    } state_t;

    localparam int N_DEF        = 8;
    localparam int PIPE_LAT_DEF = 3;
    localparam int KW_DEF       = 8;

    // Wide enough for the longest FEED (max K + N - 1) or DRAIN (N - 1 + PIPE_LAT) phase.
    function automatic int cnt_width(input int kw, input int n, input int pipe_lat);
        int feed_max;
        int drain_max;
        int top;
        feed_max  = (1 << kw) - 1 + n - 1;
        drain_max = n - 1 + pipe_lat;
        top       = (feed_max > drain_max) ? feed_max : drain_max;
        return (top < 1) ? 1 : $clog2(top + 1);
    endfunction

endpackage

// File: rtl/os_array_ctrl_if.sv
// Control/handshake bundle between the array controller and its host.
interface os_array_ctrl_if import os_array_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int KW = KW_DEF
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          acc_clr_n;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic [KW-1:0] feed_k;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic          out_ready;
    logic          done;

    modport master (
        output start, k_len, out_ready,
        input  busy, acc_clr_n, row_en, col_en, feed_k, out_valid, out_row, done
    );

    modport slave (
        input  start, k_len, out_ready,
        output busy, acc_clr_n, row_en, col_en, feed_k, out_valid, out_row, done
    );

endinterface

// File: rtl/os_skew_mask.sv
// Diagonal operand-feed skew: lane i is enabled for K cycles starting at cnt = i.
module os_skew_mask import os_array_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int KW = KW_DEF,
    parameter int CW = 9
) (
    input  logic [CW-1:0] cnt,
    input  logic [KW-1:0] k,
    input  logic          active,
    output logic [N-1:0]  row_en,
    output logic [N-1:0]  col_en
);

    logic [CW:0] cnt_x;
    assign cnt_x = {1'b0, cnt};

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [CW:0] lo;
        logic [CW:0] hi;
        assign lo        = (CW+1)'(i);
        assign hi        = lo + (CW+1)'(k);
        assign row_en[i] = active && (cnt_x >= lo) && (cnt_x < hi);
        // Square array: column j follows the same skew as row j.
        assign col_en[i] = active && (cnt_x >= lo) && (cnt_x < hi);
    end

endmodule

// File: rtl/os_array_ctrl.sv
// Tile sequencer for an N x N output-stationary MAC array: clear, skewed feed, drain, row readout.
//
// state | meaning
// IDLE  | waiting for start, k_len latched on accept
// CLEAR | one cycle, accumulators cleared (acc_clr_n low)
// FEED  | K+N-1 cycles of skewed operand feed, cnt = diagonal step
// DRAIN | N-1+PIPE_LAT cycles letting the last products land
// READ  | present result row cnt, advance on out_ready
// DONE  | one-cycle completion pulse
module os_array_ctrl import os_array_pkg::*; #(
    parameter int N        = N_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int KW       = KW_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    os_array_ctrl_if.slave   bus
);

    localparam int CW = cnt_width(KW, N, PIPE_LAT);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2 + PIPE_LAT);
    localparam logic [CW-1:0] READ_LAST  = CW'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] k_lat_nx;
    logic [CW-1:0] feed_last;
    logic          acc_clr_q;

    assign feed_last = CW'(k_lat) + CW'(N - 2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            k_lat     <= '0;
            acc_clr_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            k_lat     <= k_lat_nx;
            acc_clr_q <= (state_nx != ST_CLEAR);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        k_lat_nx = k_lat;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = '0;
                    k_lat_nx = bus.k_len;
                end
            end
            ST_CLEAR: begin
                cnt_nx   = '0;
                state_nx = (k_lat == '0) ? ST_READ : ST_FEED;
            end
            ST_FEED: begin
                if (cnt == feed_last) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = ST_READ;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_READ: begin
                if (bus.out_ready) begin
                    if (cnt == READ_LAST) begin
                        state_nx = ST_DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.acc_clr_n = acc_clr_q;
    assign bus.out_valid = (state == ST_READ);
    assign bus.done      = (state == ST_DONE);
    assign bus.feed_k    = (state == ST_FEED) ? cnt[KW-1:0] : '0;
    assign bus.out_row   = (state == ST_READ) ? cnt[RW-1:0] : '0;

    os_skew_mask #(.N(N), .KW(KW), .CW(CW)) u_skew (
        .cnt    (cnt),
        .k      (k_lat),
        .active (state == ST_FEED),
        .row_en (bus.row_en),
        .col_en (bus.col_en)
    );

endmodule

// File: doc/os_array_ctrl.md
OS_ARRAY_CTRL -- requirements
Module: os_array_ctrl

Interface
REQ-001 Parameter N, default 8: array dimension, N x N output-stationary PEs (8-bit operands, 16-bit accumulators).
REQ-002 Parameter PIPE_LAT, default 3: cycles from a PE operand input to its accumulator update (multiplier, product register, accumulate).
REQ-003 Parameter KW, default 8: width of k_len.
REQ-004 CLK  in  1  clock; reset RST, asynchronous, active-low; clock CLK.
REQ-005 RST  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle tile request; accepted only in IDLE.
REQ-007 k_len  in  KW  reduction length K; sampled with an accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 acc_clr_n  out  1  active-low accumulator clear to the array; registered output.
REQ-010 row_en  out  N  per-row X-operand feed enable, skewed.
REQ-011 col_en  out  N  per-column Y-operand feed enable, skewed.
REQ-012 feed_k  out  KW  operand index for buffer address generation; valid while FEED.
REQ-013 out_valid  out  1  result row available.
REQ-014 out_row  out  log2(N)  index of the result row presented.
REQ-015 out_ready  in  1  consumer accepts the current row.
REQ-016 done  out  1  one-cycle pulse at tile completion.

Function
REQ-017 States SHALL be IDLE, CLEAR, FEED, DRAIN, READ, DONE, with one state register and one shared counter cnt.
REQ-018 IDLE SHALL go to CLEAR on start=1; k_len SHALL be latched; cnt SHALL be set to 0.
REQ-019 CLEAR SHALL last exactly 1 cycle with acc_clr_n=0, then go to FEED, or to READ if latched K=0.
REQ-020 FEED SHALL last K+N-1 cycles (cnt 0..K+N-2); row_en[i]=1 iff i<=cnt<i+K; col_en[j]=1 iff j<=cnt<j+K; feed_k = cnt (row 0 index).
REQ-021 DRAIN SHALL last N-1+PIPE_LAT cycles with all enables 0, then go to READ with cnt=0.
REQ-022 READ: out_valid=1 and out_row=cnt; cnt SHALL advance only on out_valid&&out_ready; after row N-1 is accepted, go to DONE.
REQ-023 out_row SHALL hold stable while out_valid=1 and out_ready=0 (no timeout).
REQ-024 DONE SHALL last 1 cycle with done=1, then return to IDLE; a start in DONE is ignored.
REQ-025 start while busy=1 SHALL be ignored, with no effect on state, counter or latched K.
REQ-026 Counter width SHALL cover max(KW-bit K + N - 1, N - 1 + PIPE_LAT) with no wrap.
REQ-027 acc_clr_n SHALL be 1 in all states other than CLEAR after reset release.
REQ-028 row_en, col_en, out_valid and done SHALL be 0 outside their stated states.

Reset
REQ-029 RST=0 SHALL immediately force IDLE, cnt=0, busy=0, row_en=0, col_en=0, out_valid=0, done=0, feed_k=0, out_row=0, and acc_clr_n=0.
REQ-030 acc_clr_n SHALL go to 1 on the first CLK edge after RST release.
REQ-031 Reset mid-tile SHALL abandon the tile with no done pulse; the next start SHALL run a full tile.

Structure
REQ-032 Package os_array_pkg SHALL hold the state enum, default N and PIPE_LAT, and the counter-width function.
REQ-033 Sub-module os_skew_mask SHALL be combinational (cnt, K, active) to (row_en, col_en); it is instantiated once.

Verification
REQ-034 Parameters for all scenarios: N=4, PIPE_LAT=3.
REQ-035 Nominal run: K=5, out_ready=1, start at edge 0 -> CLEAR in cycle 1, FEED in cycles 2-9, DRAIN in 10-15, out_row 0..3 in 16-19, done in 20, IDLE in 21.
REQ-036 Skew check: K=5 -> row_en[3] is high only in FEED cycles cnt=3..7, and row_en[0] only in cnt=0..4.
REQ-037 Backpressure: out_ready=0 for 3 cycles at row 2 -> out_row holds at 2 with out_valid=1, then the tile completes with done 3 cycles later than REQ-035.
REQ-038 K=0: CLEAR goes directly to READ, 4 rows are read, and done pulses.
REQ-039 RST pulled low in DRAIN -> all outputs take reset values at once with no done; a later start with K=2 completes normally.
REQ-040 start pulsed in FEED and again in DONE -> both are ignored and the latched K stays unchanged.
